fifo_axis_reader: RTL and testbench
===================================

# fifo_axis_reader

Downstream drain stage for the synchronous first-word-fall-through FIFO. On a start command it pops a programmed number of words from the FIFO read port and presents them as an AXI4-Stream master packet, asserting `tlast` on the final word. A 2-entry output buffer gives registered stream outputs with one beat per cycle under continuous `tready`. It sits between the FIFO and any AXI-Stream sink (DMA, serializer, width converter).

## Interface
- `DATA_WIDTH`, 8: FIFO word and `tdata` width.
- `LEN_WIDTH`, 16: width of the packet-length field in words.

- `i_clk`  in  1  single clock; all logic rising-edge.
- `i_s_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start pulse; sampled only in IDLE.
- `i_pkt_len`  in  LEN_WIDTH  packet length in words, latched with `i_start`.
- `o_busy`  out  1  high whenever state is not IDLE.
- `o_done`  out  1  one-cycle pulse at packet completion.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `i_fifo_data`  in  DATA_WIDTH  FWFT head word; valid whenever `i_fifo_empty` is 0.
- `o_fifo_rd_en`  out  1  pop request.
- `o_m_axis_tdata`  out  DATA_WIDTH  stream data.
- `o_m_axis_tvalid`  out  1  stream valid.
- `o_m_axis_tlast`  out  1  last beat of packet.
- `i_m_axis_tready`  in  1  sink ready.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE → RUN on `i_start` with `i_pkt_len` ≠ 0. The block latches the length and clears `pop_cnt`.
  - `i_start` with length 0 pulses `o_done` the next cycle and stays in IDLE. No beats are produced.
  - RUN → DRAIN on the cycle the last word is popped (`pop_cnt == len-1` and pop).
  - DRAIN → IDLE on the handshake of the `tlast` beat. `o_done` is registered and asserts in the following cycle.
- `i_start` in RUN or DRAIN is ignored.
- Pop rule: `o_fifo_rd_en = RUN && !i_fifo_empty && (buf_cnt < 2 || i_m_axis_tready)`.
  - This path is combinational from `i_m_axis_tready` and `i_fifo_empty`.
  - The block never asserts `o_fifo_rd_en` while `i_fifo_empty` is 1, so FIFO underflow is impossible.
- Capture: `i_fifo_data` is written into the buffer in the same cycle as the pop, because the FWFT head changes after the pop.
  - The `tlast` flag is stored alongside each entry. It is set when `pop_cnt == len-1`.
- Buffer: 2-entry FIFO, head drives the outputs.
  - `tvalid = buf_cnt != 0`.
  - A push and a pop in the same cycle at `buf_cnt == 2` keeps the count at 2.
  - Once asserted, `tdata` and `tlast` stay stable until the handshake (AXI rule).
- `pop_cnt` is LEN_WIDTH wide and is never compared against `len` itself, so no wrap occurs. The maximum packet is 2^LEN_WIDTH − 1 words.
- Reset at any time:
  - returns to IDLE;
  - clears `buf_cnt`, `pop_cnt` and `o_done`;
  - discards any buffered words;
  - does not restore popped words to the FIFO.

## Timing
- Reset values:
  - `o_busy` = 0, `o_done` = 0, `o_fifo_rd_en` = 0.
  - `o_m_axis_tvalid` = 0, `o_m_axis_tlast` = 0, `o_m_axis_tdata` = 0.
- `i_start` at cycle T → `o_busy` = 1 at T+1. The first pop is possible at T+1.
- A pop at cycle N → the word is on `tdata` with `tvalid` at N+1, if it is at the buffer head.
- Throughput is 1 beat per cycle while the FIFO is non-empty and `tready` = 1.
- Backpressure:
  - `tready` low with `buf_cnt` = 2 stalls pops the same cycle.
  - Recovery is immediate when `tready` returns.
- The `tlast` handshake at cycle H gives `o_done` = 1 and `o_busy` = 0 at H+1. A new `i_start` is accepted at H+1.

## Structure
- Package `fifo_axis_pkg`:
  - `state_t` enum (IDLE, RUN, DRAIN);
  - buffer-entry struct {tdata, tlast};
  - localparam `BUF_DEPTH` = 2.
- Sub-module `axis_skid_buf`: the 2-entry buffer with push/data/last input and an AXIS output side. The top level holds the FSM, length latch, pop counter and pop logic.

## Test plan
- `pkt_len`=4, FIFO holds 0x11..0x14, `tready`=1 → beats 0x11..0x14 on 4 consecutive cycles. `tlast` only on 0x14; `o_done` one cycle after the 0x14 handshake.
- `pkt_len`=8 with 3 words present, the rest arriving 5 cycles later → `o_fifo_rd_en` is never high while empty. 8 beats total with `tlast` on the 8th, and `o_busy` stays high through the gap.
- `pkt_len`=6, `tready` toggling 1,0,0,1,0,1,... → data order preserved and no beat lost or duplicated. `tdata` stays stable while `tvalid && !tready`, and at most 2 words are popped ahead of the sink.
- `pkt_len`=0 → `o_done` pulse at T+1. Never `tvalid`, never `o_fifo_rd_en`.
- `i_start` pulses during RUN with `pkt_len`=2 → ignored. Exactly the original 5-word packet is sent.
- `i_s_rst`=1 mid-packet with the buffer full → next cycle `tvalid`=0 and `o_busy`=0. A following start with `pkt_len`=3 sends 3 beats starting from the FIFO's current head.

Source files
------------

// File: rtl/fifo_axis_pkg.sv
// Shared types and constants for the FIFO-to-AXI-Stream drain stage.
package fifo_axis_pkg;

  localparam int unsigned BUF_DEPTH       = 2;
  localparam int unsigned AXIS_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic                       tlast;
  } buf_entry_t;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output buffer: pushes from the FIFO read side, head drives the AXIS master outputs.
module axis_skid_buf
  import fifo_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic [1:0]            cnt,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  tvalid,
  output logic                  tlast,
  input  logic                  tready
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
  } entry_t;

  entry_t mem [BUF_DEPTH];
  logic   wr_ptr;
  logic   rd_ptr;
  logic   pop;

  assign tvalid = (cnt != '0);
  assign tdata  = mem[rd_ptr].tdata;
  assign tlast  = mem[rd_ptr].tlast;
  assign pop    = tvalid && tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{tdata: push_data, tlast: push_last};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a programmed number of words from an FWFT FIFO and emits them as one AXI4-Stream packet.
module fifo_axis_reader
  import fifo_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_s_rst,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_pkt_len,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_rd_en,
  output logic [DATA_WIDTH-1:0] o_m_axis_tdata,
  output logic                  o_m_axis_tvalid,
  output logic                  o_m_axis_tlast,
  input  logic                  i_m_axis_tready
);

  localparam logic [1:0]           BUF_FULL = 2'(BUF_DEPTH);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  state_t               state, state_next;
  logic [LEN_WIDTH-1:0] len, len_next;
  logic [LEN_WIDTH-1:0] pop_cnt, pop_cnt_next;
  logic                 done_next;
  logic [1:0]           buf_cnt;
  logic                 last_word;
  logic                 tlast_hs;

  // pop_cnt never reaches len while in RUN, so len-1 is the only value compared.
  assign last_word    = (pop_cnt == len - LEN_ONE);
  assign o_fifo_rd_en = (state == RUN) && !i_fifo_empty &&
                        ((buf_cnt < BUF_FULL) || i_m_axis_tready);
  assign tlast_hs     = o_m_axis_tvalid && i_m_axis_tready && o_m_axis_tlast;
  assign o_busy       = (state != IDLE);

  always_comb begin
    state_next   = state;
    len_next     = len;
    pop_cnt_next = pop_cnt;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (i_pkt_len != '0) begin
            state_next   = RUN;
            len_next     = i_pkt_len;
            pop_cnt_next = '0;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (o_fifo_rd_en) begin
          pop_cnt_next = pop_cnt + LEN_ONE;
          if (last_word) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (tlast_hs) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      state   <= IDLE;
      len     <= '0;
      pop_cnt <= '0;
      o_done  <= 1'b0;
    end else begin
      state   <= state_next;
      len     <= len_next;
      pop_cnt <= pop_cnt_next;
      o_done  <= done_next;
    end
  end

  axis_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (i_clk),
    .rst      (i_s_rst),
    .push     (o_fifo_rd_en),
    .push_data(i_fifo_data),
    .push_last(last_word),
    .cnt      (buf_cnt),
    .tdata    (o_m_axis_tdata),
    .tvalid   (o_m_axis_tvalid),
    .tlast    (o_m_axis_tlast),
    .tready   (i_m_axis_tready)
  );

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: FWFT FIFO model, packet-level stream model, directed packet scenarios.
module tb_fifo_axis_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic          busy, done;
  logic          fifo_empty, rd_en;
  logic [DW-1:0] fifo_data, tdata;
  logic          tvalid, tlast;
  logic          tready = 1'b0;

  always #5 clk = ~clk;

  fifo_axis_reader #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .i_clk          (clk),
    .i_s_rst        (rst),
    .i_start        (start),
    .i_pkt_len      (pkt_len),
    .o_busy         (busy),
    .o_done         (done),
    .i_fifo_empty   (fifo_empty),
    .i_fifo_data    (fifo_data),
    .o_fifo_rd_en   (rd_en),
    .o_m_axis_tdata (tdata),
    .o_m_axis_tvalid(tvalid),
    .o_m_axis_tlast (tlast),
    .i_m_axis_tready(tready)
  );

  // FWFT FIFO model: words written by the stimulus, popped on the clock edge.
  logic [DW-1:0] word_mem [0:63];
  int unsigned   wr_idx = 0;
  int unsigned   rd_idx = 0;
  int unsigned   cyc = 0;

  assign fifo_empty = (rd_idx == wr_idx);
  assign fifo_data  = word_mem[rd_idx[5:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en && !fifo_empty) rd_idx <= rd_idx + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Packet-level model: expected beats are the FIFO words in write order.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [LW-1:0] m_len = '0;
  int unsigned   beat_idx = 0;
  int unsigned   pops = 0;
  int unsigned   exp_idx = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  int unsigned   done_cnt = 0;
  int unsigned   done_cyc = 0;
  logic [DW-1:0] log_data [$];
  logic          log_last [$];
  int unsigned   log_cyc  [$];

  always @(negedge clk) begin
    logic hs;
    logic exp_last;
    hs       = tvalid && tready;
    exp_last = (beat_idx + 1 == 32'(m_len));
    if (rd_en) chk("rd_en_while_empty", fifo_empty, 0);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (!m_busy) begin
      chk("idle_tvalid", tvalid, 0);
      chk("idle_rd_en", rd_en, 0);
    end
    if (prev_stall) begin
      chk("stall_tvalid", tvalid, 1);
      chk("stall_tdata", tdata, prev_data);
      chk("stall_tlast", tlast, prev_last);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (hs) begin
      chk("beat_tdata", tdata, word_mem[exp_idx[5:0]]);
      chk("beat_tlast", tlast, exp_last);
      log_data.push_back(tdata);
      log_last.push_back(tlast);
      log_cyc.push_back(cyc);
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;

    m_done = 1'b0;
    if (rst) begin
      m_busy     = 1'b0;
      beat_idx   = 0;
      pops       = 0;
      exp_idx    = rd_idx + ((rd_en && !fifo_empty) ? 1 : 0);
      prev_stall = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        if (pkt_len == '0) begin
          m_done = 1'b1;
        end else begin
          m_busy   = 1'b1;
          m_len    = pkt_len;
          beat_idx = 0;
          pops     = 0;
        end
      end
    end else begin
      if (rd_en) begin
        pops++;
        chk("over_pop", (pops <= 32'(m_len)), 1);
      end
      if (hs) begin
        beat_idx++;
        exp_idx++;
      end
      chk("pop_ahead", (pops - beat_idx <= 2), 1);
      if (hs && exp_last) begin
        chk("pop_total", pops, 32'(m_len));
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    word_mem[wr_idx[5:0]] = d;
    wr_idx++;
  endtask

  task automatic start_pkt(input logic [LW-1:0] len);
    start   = 1'b1;
    pkt_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int unsigned max);
    int unsigned d0 = done_cnt;
    int unsigned n  = 0;
    while (done_cnt == d0 && n < max) begin
      tick();
      n++;
    end
    chk("done_timeout", (done_cnt != d0), 1);
    tick();
    tick();
  endtask

  task automatic chk_packet(input string name, input int unsigned base, input int unsigned n,
                            input logic [DW-1:0] first);
    chk({name, "_beats"}, log_data.size() - base, n);
    for (int i = 0; i < int'(n); i++) begin
      chk({name, "_data"}, log_data[base + i], first + DW'(i));
      chk({name, "_last"}, log_last[base + i], (i == int'(n) - 1));
    end
  endtask

  initial begin
    int unsigned base;
    int unsigned c0;
    int unsigned d0;
    int unsigned r0;
    logic [7:0]  pat;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    rst = 1'b0;
    tick();

    // 4-word packet, sink always ready
    base = log_data.size();
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    tready = 1'b1;
    start_pkt(16'd4);
    wait_done(40);
    chk_packet("t1", base, 4, 8'h11);
    chk("t1_consecutive", log_cyc[base + 3] - log_cyc[base], 3);
    chk("t1_done_cyc", done_cyc, log_cyc[base + 3] + 1);

    // 8-word packet, FIFO runs dry after 3 words
    base = log_data.size();
    for (int i = 0; i < 3; i++) push(8'h21 + 8'(i));
    start_pkt(16'd8);
    repeat (5) tick();
    chk("t2_busy_gap", busy, 1);
    for (int i = 3; i < 8; i++) push(8'h21 + 8'(i));
    wait_done(60);
    chk_packet("t2", base, 8, 8'h21);

    // 6-word packet under toggling backpressure
    base = log_data.size();
    for (int i = 0; i < 6; i++) push(8'h31 + 8'(i));
    start_pkt(16'd6);
    pat = 8'b1010_1001;
    d0  = done_cnt;
    for (int k = 0; k < 80 && done_cnt == d0; k++) begin
      tready = pat[k % 8];
      tick();
    end
    chk("t3_timeout", (done_cnt != d0), 1);
    tready = 1'b1;
    tick();
    tick();
    chk_packet("t3", base, 6, 8'h31);

    // zero-length start
    base = log_data.size();
    d0   = done_cnt;
    c0   = cyc;
    start_pkt(16'd0);
    repeat (3) tick();
    chk("t4_done_cyc", done_cyc, c0 + 1);
    chk("t4_done_pulses", done_cnt - d0, 1);
    chk("t4_no_beats", log_data.size() - base, 0);

    // start pulses while running are ignored
    base = log_data.size();
    d0   = done_cnt;
    for (int i = 0; i < 5; i++) push(8'h51 + 8'(i));
    start_pkt(16'd5);
    tick();
    start_pkt(16'd2);
    tick();
    start_pkt(16'd2);
    wait_done(40);
    chk_packet("t5", base, 5, 8'h51);
    chk("t5_done_pulses", done_cnt - d0, 1);
    chk("t5_idle", busy, 0);

    // reset mid-packet with the buffer full, then restart from the FIFO head
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
    r0     = rd_idx;
    tready = 1'b0;
    start_pkt(16'd6);
    repeat (4) tick();
    chk("t6_popped_ahead", rd_idx - r0, 2);
    chk("t6_tvalid_stalled", tvalid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_tvalid", tvalid, 0);
    chk("t6_rst_busy", busy, 0);
    base   = log_data.size();
    tready = 1'b1;
    start_pkt(16'd3);
    wait_done(40);
    chk_packet("t6", base, 3, 8'h63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
